// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-mispredict hazard control for the IF_ID and ID_EX registers.
// Optional HAZ_STATS_EN adds saturating mispredict and stall counters.
module pipeline_hazard_ctrl #(
    parameter int PC_WIDTH       = 8,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int RECOVER_CYCLES = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_rt,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_br_valid,
    input  logic                      ex_prediction,
    input  logic                      ex_taken,
    input  logic [PC_WIDTH-1:0]       ex_target,
    input  logic [PC_WIDTH-1:0]       ex_save_pc,
    input  logic [PC_WIDTH-1:0]       ex_pc,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      redirect_valid,
    output logic [PC_WIDTH-1:0]       redirect_pc,
`ifdef HAZ_STATS_EN
    output logic [CNT_WIDTH-1:0]      stat_mispredicts,
    output logic [CNT_WIDTH-1:0]      stat_stalls,
`endif
    output logic                      upd_valid,
    output logic                      upd_taken,
    output logic [PC_WIDTH-1:0]       upd_pc
);

    typedef enum logic {RUN, RECOVER} state_t;

    state_t              state_q, state_d;
    logic [2:0]          rec_cnt_q, rec_cnt_d;
    logic                upd_valid_q, upd_valid_d;
    logic                upd_taken_q, upd_taken_d;
    logic [PC_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic                mispredict, load_use;

    assign mispredict = ex_br_valid & (ex_taken != ex_prediction);
    assign load_use   = ex_mem_read & (ex_rd != '0) &
                        ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_comb begin
        state_d        = state_q;
        rec_cnt_d      = rec_cnt_q;
        upd_valid_d    = 1'b0;
        upd_taken_d    = upd_taken_q;
        upd_pc_d       = upd_pc_q;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = ex_taken ? ex_target : ex_save_pc;
                    if_id_flush    = 1'b1;
                    id_ex_flush    = 1'b1;
                    rec_cnt_d      = 3'(RECOVER_CYCLES);
                    if (RECOVER_CYCLES != 0) state_d = RECOVER;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
                if (ex_br_valid) begin
                    upd_valid_d = 1'b1;
                    upd_taken_d = ex_taken;
                    upd_pc_d    = ex_pc;
                end
            end
            RECOVER: begin
                // EX holds only bubbles here, so hazard inputs are not examined
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                rec_cnt_d   = rec_cnt_q - 3'd1;
                if (rec_cnt_q <= 3'd1) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        // Hold the pipeline in its plain-advance configuration while reset is asserted
        if (reset) begin
            pc_write       = 1'b1;
            if_id_write    = 1'b1;
            if_id_flush    = 1'b0;
            id_ex_flush    = 1'b0;
            redirect_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            rec_cnt_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            rec_cnt_q   <= rec_cnt_d;
            upd_valid_q <= upd_valid_d;
            upd_taken_q <= upd_taken_d;
            upd_pc_q    <= upd_pc_d;
        end
    end

    assign upd_valid = upd_valid_q;
    assign upd_taken = upd_taken_q;
    assign upd_pc    = upd_pc_q;

`ifdef HAZ_STATS_EN
    logic [CNT_WIDTH-1:0] stat_mis_q, stat_mis_d;
    logic [CNT_WIDTH-1:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_mis_d   = stat_mis_q;
        stat_stall_d = stat_stall_q;
        if (state_q == RUN) begin
            if (mispredict) begin
                if (stat_mis_q != '1) stat_mis_d = stat_mis_q + 1'b1;
            end else if (load_use) begin
                if (stat_stall_q != '1) stat_stall_d = stat_stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_mis_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_mis_q   <= stat_mis_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_mispredicts = stat_mis_q;
    assign stat_stalls      = stat_stall_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
    localparam int PW = 8;
    localparam int RW = 5;
    localparam int RC = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    logic [RW-1:0] id_rs, id_rt, ex_rd;
    logic id_uses_rt, ex_mem_read, ex_br_valid, ex_prediction, ex_taken;
    logic [PW-1:0] ex_target, ex_save_pc, ex_pc;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, redirect_valid;
    logic [PW-1:0] redirect_pc;
    logic upd_valid, upd_taken;
    logic [PW-1:0] upd_pc;
`ifdef HAZ_STATS_EN
    logic [CW-1:0] stat_mispredicts, stat_stalls;
`endif

    pipeline_hazard_ctrl #(.PC_WIDTH(PW), .REG_ADDR_WIDTH(RW), .RECOVER_CYCLES(RC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_br_valid(ex_br_valid), .ex_prediction(ex_prediction), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_save_pc(ex_save_pc), .ex_pc(ex_pc),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef HAZ_STATS_EN
        .stat_mispredicts(stat_mispredicts), .stat_stalls(stat_stalls),
`endif
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state: remaining bubble cycles, predictor update, counters
    int        m_bub = 0;
    logic      m_uv = 1'b0, m_ut = 1'b0;
    logic [PW-1:0] m_upc = '0;
    int        m_smis = 0, m_sstall = 0;
    localparam int SAT = (1 << CW) - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input bit uses, input bit mr, input int rd,
                         input bit bv, input bit pred, input bit tk,
                         input int tgt, input int spc, input int pc);
        id_rs = RW'(rs); id_rt = RW'(rt); id_uses_rt = uses;
        ex_mem_read = mr; ex_rd = RW'(rd);
        ex_br_valid = bv; ex_prediction = pred; ex_taken = tk;
        ex_target = PW'(tgt); ex_save_pc = PW'(spc); ex_pc = PW'(pc);
    endtask

    task automatic model_reset();
        m_bub = 0; m_uv = 1'b0; m_ut = 1'b0; m_upc = '0; m_smis = 0; m_sstall = 0;
    endtask

    // called at posedge+1 with inputs driven; checks at negedge, then advances one clock
    task automatic step();
        bit mis, lu;
        logic [4:0] ctrl;
        logic [PW-1:0] rpc;
        #4;
        mis = ex_br_valid && (ex_taken != ex_prediction);
        lu  = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        rpc = ex_taken ? ex_target : ex_save_pc;
        // {pc_write, if_id_write, if_id_flush, id_ex_flush, redirect_valid}
        if (m_bub > 0)   ctrl = 5'b11110;
        else if (mis)    ctrl = 5'b11111;
        else if (lu)     ctrl = 5'b00010;
        else             ctrl = 5'b11000;
        chk("ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, redirect_valid}, {27'd0, ctrl});
        if (m_bub == 0) chk("redirect_pc", {24'd0, redirect_pc}, mis ? {24'd0, rpc} : 32'd0);
        chk("upd", {23'd0, upd_valid, upd_taken, upd_pc}, {23'd0, m_uv, m_ut, m_upc});
`ifdef HAZ_STATS_EN
        chk("stat_mis", {28'd0, stat_mispredicts}, m_smis);
        chk("stat_stall", {28'd0, stat_stalls}, m_sstall);
`endif
        @(posedge clk);
        if (m_bub == 0 && ex_br_valid) begin
            m_uv = 1'b1; m_ut = ex_taken; m_upc = ex_pc;
        end else m_uv = 1'b0;
        if (m_bub == 0 && mis)     m_smis   = (m_smis == SAT) ? SAT : m_smis + 1;
        else if (m_bub == 0 && lu) m_sstall = (m_sstall == SAT) ? SAT : m_sstall + 1;
        if (m_bub > 0) m_bub--;
        else if (mis)  m_bub = RC;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, redirect_valid}, 32'h18);
        chk("rst_upd", {23'd0, upd_valid, upd_taken, upd_pc}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // correct predictions: no redirect, but predictor is trained
        drive(1, 2, 1, 0, 0, 1, 1, 1, 8'h20, 8'h05, 8'h04); step();
        drive(1, 2, 1, 0, 0, 1, 0, 0, 8'h30, 8'h09, 8'h08); step();
`ifdef HAZ_STATS_EN
        chk("stat_mis_zero", {28'd0, stat_mispredicts}, 32'd0);
`endif
        // 20 back-to-back stall cycles saturate a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(5, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0); step();
        end
`ifdef HAZ_STATS_EN
        chk("stat_stall_sat", {28'd0, stat_stalls}, 32'hF);
`endif
        // load-use via rs, then bubble in EX clears it
        drive(5, 1, 1, 1, 5, 0, 0, 0, 0, 0, 0); step();
        drive(5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
        // r0 never stalls; rt ignored unless used
        drive(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0); step();
        drive(3, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0); step();
        drive(3, 7, 1, 1, 7, 0, 0, 0, 0, 0, 0); step();
        // predicted not-taken, actually taken -> target, then RC recovery cycles
        drive(1, 2, 0, 0, 0, 1, 0, 1, 8'h40, 8'h11, 8'h10); step();
        drive(4, 4, 1, 1, 4, 1, 0, 1, 8'h77, 8'h66, 8'h55); step();
        drive(4, 4, 1, 1, 4, 0, 0, 0, 0, 0, 0); step();
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        // mispredict beats a simultaneous load-use
        drive(5, 0, 0, 1, 5, 1, 1, 0, 8'h80, 8'h13, 8'h12); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        step();
        step();
        // reset asserted mid-recovery
        drive(1, 2, 0, 0, 0, 1, 0, 1, 8'h22, 8'h33, 8'h21); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("midrec_rst_ctrl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, redirect_valid}, 32'h18);
        chk("midrec_rst_upd", {31'd0, upd_valid}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        step();

        // random traffic, small register range to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3),
                  ($urandom_range(0, 9) < 3), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
